// File: rtl/seq_det_pkg.sv
// Shared encodings and helpers for the serial sequence-detector controller.
package seq_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HOLD = 2'b10
   } state_t;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked pattern comparator: bits at or above len always compare equal.
module seq_match_cmp
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int LEN_W = clog2(PAT_W + 1)
) (
   input  logic [PAT_W-1:0] hist,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             eq
);

   logic [PAT_W-1:0] bit_ok;

   for (genvar i = 0; i < PAT_W; i++) begin : g_bit
      assign bit_ok[i] = (hist[i] ~^ pattern[i]) | (LEN_W'(i) >= len);
   end

   assign eq = &bit_ok;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence detector with optional post-match hold-off.
// state   | meaning
// IDLE    | configuration accepted, stream ignored
// RUN     | shifting bits and comparing against the pattern
// HOLD    | one-cycle hold-off after a non-overlapping match
module seq_detect_ctrl
   import seq_det_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             start,
   input  logic             stop,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             busy,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cfg_err
);

   state_t           state_q, state_d;
   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             overlap_q, overlap_d;
   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic             match_q, match_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cfg_err_q, cfg_err_d;

   logic [PAT_W-1:0] hist_shift;
   logic [LEN_W-1:0] fill_inc;
   logic             cmp_eq;
   logic             hit;
   logic             len_legal;

   assign hist_shift = {hist_q[PAT_W-2:0], bit_in};
   assign fill_inc   = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
   assign len_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

   seq_match_cmp #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_cmp (
      .hist    (hist_shift),
      .pattern (pattern_q),
      .len     (len_q),
      .eq      (cmp_eq)
   );

   assign hit = (state_q == ST_RUN) && bit_valid && (fill_inc >= len_q) && cmp_eq;

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      cfg_err_d = cfg_err_q;
      match_d   = hit;
      cnt_d     = cnt_q;

      if (hit && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_load) begin
               if (len_legal) begin
                  pattern_d = cfg_pattern;
                  len_d     = cfg_len;
                  overlap_d = cfg_overlap;
                  cfg_err_d = 1'b0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end else if (start && !stop && (len_q != '0) && !cfg_err_q) begin
               state_d = ST_RUN;
               hist_d  = '0;
               fill_d  = '0;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            if (bit_valid) begin
               hist_d = hist_shift;
               fill_d = fill_inc;
               if (hit && !overlap_q) begin
                  state_d = ST_HOLD;
                  fill_d  = '0;
               end
            end
         end
         ST_HOLD: state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase

      // A match computed in the stop cycle is still pulsed and counted.
      if (stop) begin
         state_d = ST_IDLE;
         hist_d  = '0;
         fill_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pattern_q <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         hist_q    <= '0;
         fill_q    <= '0;
         match_q   <= 1'b0;
         cnt_q     <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         cnt_q     <= cnt_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus randomized run against a queue-based model.
module tb_seq_detect_ctrl;

   localparam int PAT_W = 8;
   localparam int LEN_W = 4;

   logic             clk;
   logic             rst_n;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic             start;
   logic             stop;
   logic             bit_valid;
   logic             bit_in;

   logic       busy, match, cfg_err;
   logic [7:0] match_cnt;
   logic       busy2, match2, cfg_err2;
   logic [1:0] match_cnt2;

   int errors = 0;
   int checks = 0;

   seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
      .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy), .match(match),
      .match_cnt(match_cnt), .cfg_err(cfg_err)
   );

   seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
      .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy2), .match(match2),
      .match_cnt(match_cnt2), .cfg_err(cfg_err2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
      start = 0; stop = 0; bit_valid = 0; bit_in = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) tick();
      rst_n = 1;
      tick();
   endtask

   task automatic load_cfg(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ovl);
      cfg_load = 1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
      tick();
      cfg_load = 0;
   endtask

   task automatic pulse_start();
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({busy, match, match_cnt, cfg_err} !== 11'b0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b match=%b cnt=%0d err=%b, want all 0",
                  busy, match, match_cnt, cfg_err);
      end
      checks++;
      if ({busy2, match2, match_cnt2, cfg_err2} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs_cnt2: got busy=%b match=%b cnt=%0d err=%b, want all 0",
                  busy2, match2, match_cnt2, cfg_err2);
      end
   endtask

   task automatic test_overlap(input logic ovl);
      int   bits[7]  = '{1, 0, 1, 1, 0, 1, 1};
      logic exp_m[7];
      exp_m = ovl ? '{0, 0, 0, 1, 0, 0, 1} : '{0, 0, 0, 1, 0, 0, 0};
      do_reset();
      load_cfg(8'b0000_1011, 4'd4, ovl);
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL start_busy(ovl=%0b): got %b want 1", ovl, busy);
      end
      for (int i = 0; i < 7; i++) begin
         bit_valid = 1; bit_in = bits[i][0];
         tick();
         checks++;
         if (match !== exp_m[i]) begin
            errors++;
            $display("FAIL stream_match(ovl=%0b,bit=%0d): got %b want %b", ovl, i + 1, match, exp_m[i]);
         end
      end
      bit_valid = 0;
      tick();
      checks++;
      if (match_cnt !== (ovl ? 8'd2 : 8'd1) || match !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL stream_end(ovl=%0b): got cnt=%0d match=%b busy=%b want cnt=%0d match=0 busy=1",
                  ovl, match_cnt, match, busy, ovl ? 2 : 1);
      end
   endtask

   task automatic test_cfg_err();
      do_reset();
      load_cfg(8'h05, 4'd0, 0);
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_len0_err: got %b want 1", cfg_err); end
      pulse_start();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL cfg_len0_start: busy got %b want 0", busy); end
      load_cfg(8'h05, 4'd9, 0);
      checks++;
      if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_len9_err: got %b want 1", cfg_err); end
      pulse_start();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL cfg_len9_start: busy got %b want 0", busy); end
      load_cfg(8'h05, 4'd3, 0);
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_legal_clear: got %b want 0", cfg_err); end
      start = 1; cfg_load = 1; cfg_len = 4'd0;
      tick();
      start = 0; cfg_load = 0;
      checks++;
      if (busy !== 1'b0 || cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL load_beats_start: got busy=%b err=%b want busy=0 err=1", busy, cfg_err);
      end
      load_cfg(8'h05, 4'd3, 0);
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL cfg_legal_start: busy got %b want 1", busy); end
      load_cfg(8'h00, 4'd0, 0);
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL load_outside_idle: err got %b want 0", cfg_err); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp2[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      load_cfg(8'h01, 4'd1, 1);
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         bit_valid = 1; bit_in = 1;
         tick();
         checks++;
         if (match2 !== 1'b1 || match_cnt2 !== exp2[i] || match_cnt !== 8'(i + 1)) begin
            errors++;
            $display("FAIL sat_cnt(%0d): got match=%b cnt2=%0d cnt8=%0d want 1/%0d/%0d",
                     i, match2, match_cnt2, match_cnt, exp2[i], i + 1);
         end
      end
      bit_valid = 0;
   endtask

   task automatic test_async_reset();
      int bits[6] = '{1, 0, 1, 1, 0, 1};
      do_reset();
      load_cfg(8'b0000_1011, 4'd4, 1);
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         bit_valid = 1; bit_in = bits[i][0];
         tick();
      end
      bit_valid = 0;
      checks++;
      if (match_cnt !== 8'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got cnt=%0d busy=%b want 1/1", match_cnt, busy);
      end
      #2;
      rst_n = 0;
      #1;
      checks++;
      if ({busy, match, match_cnt, cfg_err} !== 11'b0) begin
         errors++;
         $display("FAIL async_reset: got busy=%b match=%b cnt=%0d err=%b want all 0",
                  busy, match, match_cnt, cfg_err);
      end
      repeat (3) tick();
      #2;
      rst_n = 1;
      bit_valid = 1; bit_in = 1;
      tick();
      bit_valid = 0;
      checks++;
      if (match !== 1'b0 || match_cnt !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_bit: got match=%b cnt=%0d busy=%b want 0/0/0", match, match_cnt, busy);
      end
   endtask

   task automatic test_stop_on_match();
      int bits[3] = '{1, 0, 1};
      do_reset();
      load_cfg(8'b0000_1011, 4'd4, 1);
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1; bit_in = bits[i][0];
         tick();
      end
      bit_valid = 1; bit_in = 1; stop = 1;
      tick();
      bit_valid = 0; stop = 0;
      checks++;
      if (match !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd1) begin
         errors++;
         $display("FAIL stop_match: got match=%b busy=%b cnt=%0d want 1/0/1", match, busy, match_cnt);
      end
      tick();
      checks++;
      if (match !== 1'b0 || match_cnt !== 8'd1) begin
         errors++;
         $display("FAIL stop_hold: got match=%b cnt=%0d want 0/1", match, match_cnt);
      end
      pulse_start();
      checks++;
      if (busy !== 1'b1 || match_cnt !== 8'd0) begin
         errors++;
         $display("FAIL restart_clear: got busy=%b cnt=%0d want 1/0", busy, match_cnt);
      end
   endtask

   // Reference model: bits since start kept in a queue, matches found by looking back len bits.
   typedef enum {M_IDLE, M_RUN, M_HOLD} mode_t;

   task automatic test_random();
      mode_t m_mode = M_IDLE;
      logic [PAT_W-1:0] m_pat = '0;
      int   m_len = 0, m_fill = 0, m_cnt8 = 0, m_cnt2 = 0;
      logic m_ovl = 0, m_err = 0, m_match;
      bit   q_bits[$];
      logic hit;
      do_reset();
      for (int it = 0; it < 600; it++) begin
         idle_inputs();
         if (m_mode == M_IDLE) begin
            cfg_load    = ($urandom_range(0, 3) == 0);
            cfg_len     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 4));
            cfg_pattern = 8'($urandom);
            cfg_overlap = 1'($urandom);
            start       = ($urandom_range(0, 2) == 0);
         end else begin
            cfg_load = ($urandom_range(0, 15) == 0);
            cfg_len  = 4'd0;
            start    = ($urandom_range(0, 7) == 0);
         end
         stop      = ($urandom_range(0, 39) == 0);
         bit_valid = ($urandom_range(0, 3) != 0);
         bit_in    = 1'($urandom);

         m_match = 0;
         case (m_mode)
            M_IDLE: begin
               if (cfg_load) begin
                  if (cfg_len >= 1 && int'(cfg_len) <= PAT_W) begin
                     m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_err = 0;
                  end else m_err = 1;
               end else if (start && !stop && m_len != 0 && !m_err) begin
                  m_mode = M_RUN; q_bits.delete(); m_fill = 0; m_cnt8 = 0; m_cnt2 = 0;
               end
            end
            M_RUN: begin
               if (bit_valid) begin
                  q_bits.push_back(bit_in);
                  if (q_bits.size() > PAT_W) void'(q_bits.pop_front());
                  m_fill++;
                  hit = (m_fill >= m_len);
                  for (int i = 0; i < m_len && hit; i++)
                     if (q_bits[q_bits.size() - 1 - i] != m_pat[i]) hit = 0;
                  if (hit) begin
                     m_match = 1;
                     if (m_cnt8 < 255) m_cnt8++;
                     if (m_cnt2 < 3) m_cnt2++;
                     if (!m_ovl) begin m_mode = M_HOLD; m_fill = 0; end
                  end
               end
            end
            M_HOLD: m_mode = M_RUN;
            default: m_mode = M_IDLE;
         endcase
         if (stop) begin m_mode = M_IDLE; q_bits.delete(); m_fill = 0; end

         tick();
         checks++;
         if (match !== m_match || match_cnt !== 8'(m_cnt8) || match_cnt2 !== 2'(m_cnt2) ||
             busy !== (m_mode != M_IDLE) || cfg_err !== m_err) begin
            errors++;
            $display("FAIL random(%0d): got m=%b c=%0d c2=%0d b=%b e=%b want m=%b c=%0d c2=%0d b=%b e=%b",
                     it, match, match_cnt, match_cnt2, busy, cfg_err,
                     m_match, m_cnt8, m_cnt2, (m_mode != M_IDLE), m_err);
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      test_reset();
      test_overlap(1'b1);
      test_overlap(1'b0);
      test_cfg_err();
      test_saturation();
      test_async_reset();
      test_stop_on_match();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
